// File: rtl/irq_pkg.sv
// Shared types and register map for the interrupt controller.
// IRQ_EDGE_EN selects edge-latched pending bits; default is level mode.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_ACTIVE  = 2'd3;

    localparam logic [15:0] ACTIVE_NONE = 16'hFFFF;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt controller.
// Index 0 is the highest priority source.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);

    always_comb begin
        valid = |req;
        idx   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt source side of the irq/reset_irq handshake with MMIO control.
// Define IRQ_EDGE_EN for sticky edge-latched pending bits; otherwise level.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_SOURCES     = 8,
    parameter logic [15:0] VECTOR_BASE   = 16'hFF00,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0010
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_SOURCES-1:0] irq_src,
    output logic                 irq,
    output logic [15:0]          irq_vector,
    input  logic                 reset_irq,
    input  logic                 reg_we,
    input  logic [1:0]           reg_addr,
    input  logic [15:0]          reg_wdata,
    output logic [15:0]          reg_rdata
);

    localparam int N = N_SOURCES;

    logic [N-1:0] s1_q, s1_d;
    logic [N-1:0] s2_q, s2_d;
    logic [N-1:0] mask_q, mask_d;
    logic         ctrl_q, ctrl_d;
    irq_state_t   state_q, state_d;
    logic [3:0]   id_q, id_d;
    logic         irq_q, irq_d;
    logic [15:0]  vec_q, vec_d;
    logic [15:0]  active_q, active_d;

    logic [N-1:0] pending;
    logic [N-1:0] eligible;
    logic         win_valid;
    logic [3:0]   win_idx;
    logic         ack_fire;
    logic         unused_wdata;

    assign unused_wdata = ^reg_wdata;
    assign ack_fire     = (state_q == ASSERT) && reset_irq;

    always_comb begin
        s1_d = irq_src;
        s2_d = s1_q;
    end

`ifdef IRQ_EDGE_EN
    logic [N-1:0] s3_q, s3_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] rise;
    logic [N-1:0] ack_clr;
    logic [N-1:0] w1c_clr;

    // A new edge always wins over either clear so no event is lost.
    always_comb begin
        s3_d = s2_q;
        rise = s2_q & ~s3_q;
        w1c_clr = '0;
        if (reg_we && reg_addr == REG_PENDING) begin
            w1c_clr = reg_wdata[N-1:0];
        end
        for (int i = 0; i < N; i++) begin
            ack_clr[i] = ack_fire && (id_q == 4'(i));
        end
        pending_d = rise | (pending_q & ~(ack_clr | w1c_clr));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s3_q      <= '0;
            pending_q <= '0;
        end else begin
            s3_q      <= s3_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    assign pending = s2_q;
`endif

    assign eligible = pending & mask_q & {N{ctrl_q}};

    irq_prio_enc #(
        .N (N)
    ) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        mask_d = mask_q;
        ctrl_d = ctrl_q;
        if (reg_we && reg_addr == REG_MASK) begin
            mask_d = reg_wdata[N-1:0];
        end
        if (reg_we && reg_addr == REG_CTRL) begin
            ctrl_d = reg_wdata[0];
        end
    end

    // Request, id and vector stay frozen from grant until acknowledge.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        irq_d    = irq_q;
        vec_d    = vec_q;
        active_d = active_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = ASSERT;
                    id_d     = win_idx;
                    irq_d    = 1'b1;
                    vec_d    = VECTOR_BASE + 16'(win_idx) * VECTOR_STRIDE;
                    active_d = {12'd0, win_idx};
                end
            end
            ASSERT: begin
                if (reset_irq) begin
                    state_d = HOLDOFF;
                    irq_d   = 1'b0;
                end
            end
            HOLDOFF: begin
                state_d  = IDLE;
                active_d = ACTIVE_NONE;
            end
            default: begin
                state_d  = IDLE;
                irq_d    = 1'b0;
                active_d = ACTIVE_NONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            mask_q   <= '0;
            ctrl_q   <= 1'b0;
            state_q  <= IDLE;
            id_q     <= 4'd0;
            irq_q    <= 1'b0;
            vec_q    <= VECTOR_BASE;
            active_q <= ACTIVE_NONE;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            mask_q   <= mask_d;
            ctrl_q   <= ctrl_d;
            state_q  <= state_d;
            id_q     <= id_d;
            irq_q    <= irq_d;
            vec_q    <= vec_d;
            active_q <= active_d;
        end
    end

    assign irq        = irq_q;
    assign irq_vector = vec_q;

    always_comb begin
        reg_rdata = '0;
        unique case (reg_addr)
            REG_MASK:    reg_rdata[N-1:0] = mask_q;
            REG_PENDING: reg_rdata[N-1:0] = pending;
            REG_CTRL:    reg_rdata[0]     = ctrl_q;
            REG_ACTIVE:  reg_rdata        = active_q;
            default:     reg_rdata        = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register table plus handshake sequences.
// Sequences follow the configured pending mode (IRQ_EDGE_EN or level).
module tb_irq_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic        irq;
    logic [15:0] irq_vector;
    logic        reset_irq;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       nm;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    irq_controller #(
        .N_SOURCES     (8),
        .VECTOR_BASE   (16'hFF00),
        .VECTOR_STRIDE (16'h0010)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .irq        (irq),
        .irq_vector (irq_vector),
        .reset_irq  (reset_irq),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic ack();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
    endtask

    task automatic wait_irq(input string nm, input logic [15:0] v);
        int n = 0;
        while (irq !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk({nm, "_irq"}, 16'(irq), 16'h0001);
        chk({nm, "_vec"}, irq_vector, v);
    endtask

    task automatic quiet(input string nm, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (irq !== 1'b0) seen = 1'b1;
        end
        chk(nm, 16'(seen), 16'h0000);
    endtask

    initial begin
        logic [15:0] d;

        tbl[0] = '{"mask_wr",  1'b1, 2'd0, 16'hFFAB, 16'h00AB};
        tbl[1] = '{"ctrl_on",  1'b1, 2'd2, 16'hFFFF, 16'h0001};
        tbl[2] = '{"pend_rd",  1'b0, 2'd1, 16'h0000, 16'h0000};
        tbl[3] = '{"ctrl_off", 1'b1, 2'd2, 16'h0000, 16'h0000};
        tbl[4] = '{"act_ro",   1'b1, 2'd3, 16'h1234, 16'hFFFF};
        tbl[5] = '{"pend_w1c", 1'b1, 2'd1, 16'h00FF, 16'h0000};
        tbl[6] = '{"mask_clr", 1'b1, 2'd0, 16'h0000, 16'h0000};
        tbl[7] = '{"mask_rd",  1'b0, 2'd0, 16'h0000, 16'h0000};

        reset     = 1'b0;
        irq_src   = '0;
        reset_irq = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = 2'd0;
        reg_wdata = '0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        tick();

        chk("rst_irq", 16'(irq), 16'h0000);
        chk("rst_vec", irq_vector, 16'hFF00);
        rd(2'd3, d);
        chk("rst_active", d, 16'hFFFF);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, d);
            chk(tbl[i].nm, d, tbl[i].exp);
        end

        // Read during a write cycle returns the old value.
        reg_we    = 1'b1;
        reg_addr  = 2'd0;
        reg_wdata = 16'h0055;
        #1;
        chk("rbw_old", reg_rdata, 16'h0000);
        tick();
        reg_we = 1'b0;
        rd(2'd0, d);
        chk("rbw_new", d, 16'h0055);

`ifdef IRQ_EDGE_EN
        wr(2'd0, 16'h0004);
        wr(2'd2, 16'h0001);
        irq_src = 8'h04;
        tick();
        chk("e_lat_k", 16'(irq), 16'h0000);
        tick();
        irq_src = 8'h00;
        chk("e_lat_k1", 16'(irq), 16'h0000);
        tick();
        chk("e_lat_k2", 16'(irq), 16'h0000);
        rd(2'd1, d);
        chk("e_pend_set", d, 16'h0004);
        tick();
        chk("e_lat_k3", 16'(irq), 16'h0001);
        chk("e_vec2", irq_vector, 16'hFF20);
        rd(2'd3, d);
        chk("e_active2", d, 16'h0002);
        ack();
        chk("e_ack_irq", 16'(irq), 16'h0000);
        rd(2'd1, d);
        chk("e_ack_pend", d, 16'h0000);
        tick();
        chk("e_hold_irq", 16'(irq), 16'h0000);

        wr(2'd0, 16'h00FF);
        irq_src = 8'h22;
        tick();
        tick();
        irq_src = 8'h00;
        wait_irq("e_prio1", 16'hFF10);
        ack();
        wait_irq("e_prio2", 16'hFF50);
        ack();
        quiet("e_prio_done", 5);

        irq_src = 8'h04;
        tick();
        tick();
        irq_src = 8'h00;
        wait_irq("e_col1", 16'hFF20);
        tick();
        tick();
        irq_src = 8'h04;
        tick();
        tick();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
        irq_src = 8'h00;
        chk("e_col_irq0", 16'(irq), 16'h0000);
        rd(2'd1, d);
        chk("e_col_pend", d, 16'h0004);
        tick();
        chk("e_col_idle", 16'(irq), 16'h0000);
        tick();
        chk("e_col2_irq", 16'(irq), 16'h0001);
        chk("e_col2_vec", irq_vector, 16'hFF20);
        ack();
        tick();

        wr(2'd2, 16'h0000);
        irq_src = 8'h04;
        tick();
        tick();
        irq_src = 8'h00;
        tick();
        tick();
        rd(2'd1, d);
        chk("e_w1c_pre", d, 16'h0004);
        wr(2'd1, 16'h0004);
        rd(2'd1, d);
        chk("e_w1c_post", d, 16'h0000);

        wr(2'd2, 16'h0001);
        irq_src = 8'h08;
        tick();
        tick();
        irq_src = 8'h00;
        wait_irq("e_frz", 16'hFF30);
        irq_src = 8'h20;
        tick();
        tick();
        irq_src = 8'h00;
        wr(2'd0, 16'h0000);
        wr(2'd2, 16'h0000);
        tick();
        chk("e_frz_irq", 16'(irq), 16'h0001);
        chk("e_frz_vec", irq_vector, 16'hFF30);
        ack();
        quiet("e_frz_quiet", 6);
        rd(2'd1, d);
        chk("e_frz_pend", d, 16'h0020);
        wr(2'd1, 16'h0020);
        rd(2'd1, d);
        chk("e_frz_w1c", d, 16'h0000);
`else
        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'h0001);
        irq_src = 8'h01;
        tick();
        chk("l_lat_k", 16'(irq), 16'h0000);
        tick();
        chk("l_lat_k1", 16'(irq), 16'h0000);
        rd(2'd1, d);
        chk("l_pend_live", d, 16'h0001);
        tick();
        chk("l_lat_k2", 16'(irq), 16'h0001);
        chk("l_vec0", irq_vector, 16'hFF00);
        rd(2'd3, d);
        chk("l_active0", d, 16'h0000);
        ack();
        chk("l_ack_irq", 16'(irq), 16'h0000);
        tick();
        chk("l_hold_irq", 16'(irq), 16'h0000);
        rd(2'd3, d);
        chk("l_hold_act", d, 16'hFFFF);
        tick();
        chk("l_refire", 16'(irq), 16'h0001);
        irq_src = 8'h00;
        tick();
        tick();
        tick();
        chk("l_hold_high", 16'(irq), 16'h0001);
        ack();
        quiet("l_drop_quiet", 6);

        irq_src = 8'h22;
        wait_irq("l_prio1", 16'hFF10);
        irq_src = 8'h20;
        tick();
        tick();
        tick();
        ack();
        wait_irq("l_prio2", 16'hFF50);
        irq_src = 8'h00;
        tick();
        tick();
        tick();
        ack();
        quiet("l_prio_done", 4);

        irq_src = 8'h08;
        wait_irq("l_frz", 16'hFF30);
        irq_src = 8'h28;
        wr(2'd0, 16'h0000);
        wr(2'd2, 16'h0000);
        tick();
        chk("l_frz_irq", 16'(irq), 16'h0001);
        chk("l_frz_vec", irq_vector, 16'hFF30);
        ack();
        quiet("l_frz_quiet", 6);
        rd(2'd1, d);
        chk("l_frz_pend", d, 16'h0028);
        wr(2'd1, 16'h00FF);
        rd(2'd1, d);
        chk("l_w1c_noop", d, 16'h0028);
        irq_src = 8'h00;
        tick();
        tick();
`endif

        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'h0001);
        irq_src = 8'h01;
        wait_irq("mid", 16'hFF00);
        reset = 1'b0;
        #1;
        chk("mid_rst_irq", 16'(irq), 16'h0000);
        rd(2'd3, d);
        chk("mid_rst_act", d, 16'hFFFF);
        rd(2'd0, d);
        chk("mid_rst_mask", d, 16'h0000);
        irq_src = 8'h00;
        reset = 1'b1;
        quiet("mid_rst_quiet", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
